hgcal_input_quantizer: RTL and testbench
========================================

Name: hgcal_input_quantizer

Overview:
- Upstream feeder for the hgcal_quant4 layer-0 LUT neurons.
- Accepts a serial stream of unsigned sensor-cell samples over valid/ready and quantizes each sample to a Q_W-bit code using fixed thresholds.
- Packs N_CELLS codes into one wide frame word and presents it to layer 0 over a valid/ready handshake; each layer-0 neuron taps its 8-bit fan-in slice from that word.
- Provides one frame of buffering so the stream can fill the next frame while the current one is held.

Parameters:
- N_CELLS, 48, number of cells per frame.
- IN_W, 8, input sample width (unsigned).
- Q_W, 2, quantized code width; fixed at 2 (4 levels).
- T1, 8, lower threshold for code 1.
- T2, 32, threshold for code 2.
- T3, 96, threshold for code 3. Elaboration requires T1<=T2<=T3<2^IN_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_data  in  IN_W  unsigned sample
- s_last  in  1  marks the final sample of a frame
- m_valid  out  1  frame valid to layer 0
- m_ready  in  1  layer 0 accepts frame
- m_data  out  N_CELLS*Q_W  packed codes; cell i occupies [i*Q_W +: Q_W]
- err_frame  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (asynchronous assert, synchronous deassert): m_valid=0, m_data=0, err_frame=0, idx=0, fill buffer=0, state=FILL. s_ready=1 from the first cycle after reset.
- Quantize (combinational per beat): code=3 if x>=T3; else 2 if x>=T2; else 1 if x>=T1; else 0. Unsigned compare.
- Beat transfer occurs when s_valid&&s_ready. Transfer writes the code into fill[idx], then idx increments.
- Frame transfer occurs when m_valid&&m_ready.
- Output register (OREG) is free when !m_valid or a frame transfer occurs in the same cycle.
- State FILL: s_ready=1.
  - Beat with idx<N_CELLS-1 and !s_last: stay in FILL.
  - Beat with idx==N_CELLS-1 and s_last: frame complete.
  - Beat with idx<N_CELLS-1 and s_last (short frame): cells idx+1..N_CELLS-1 are zero-padded; frame complete; err_frame pulses next cycle.
  - Beat with idx==N_CELLS-1 and !s_last (long frame): frame complete; err_frame pulses; the following state is DROP instead of FILL.
- Frame complete:
  - If OREG is free that cycle: the fill word (including this beat) loads into m_data, m_valid=1 next cycle, fill buffer clears, idx=0, state goes to FILL (or DROP).
  - Otherwise state goes to WAIT.
- Latency: last beat accepted at cycle t gives m_valid=1 at t+1 when OREG is free.
- State WAIT: s_ready=0. When OREG becomes free, load m_data, clear fill, idx=0, and go to FILL (or DROP if the frame was long).
- State DROP: s_ready=1. Beats are discarded. The beat with s_last returns the state to FILL; that beat is also discarded.
- m_data/m_valid are held stable while m_valid&&!m_ready.
- Back-to-back: a frame transfer and an OREG load in the same cycle keep m_valid=1 with the new data.
- s_valid=0 mid-frame: idx holds with no timeout.
- Reset mid-frame discards the partial frame and OREG contents.

Optional Feature:
- Macro: HGCAL_QIN_STATS_EN.
- Defined: adds output ports frames_out[15:0] and frames_err[15:0].
  - frames_out increments on each frame transfer.
  - frames_err increments on each err_frame pulse.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Nominal frame: 48 beats with s_data=0,8,32,96 repeating, s_last on beat 48, m_ready=1 → m_valid at cycle after beat 48; m_data[1:0]=0, [3:2]=1, [5:4]=2, [7:6]=3, pattern repeating; err_frame=0.
- Thresholds: s_data=7,8,31,32,95,96,255 on cells 0..6 → codes 0,1,1,2,2,3,3.
- Backpressure: m_ready=0, send frame A (all 255) then 48 beats of frame B (all 0).
  - s_ready drops after B's last beat; m_data stays all 1s.
  - Raise m_ready one cycle → next cycle m_data=0 with m_valid still 1; s_ready=1.
- Short frame: 10 beats of 255 with s_last on beat 10 → cells 0..9=3, cells 10..47=0, err_frame pulses once.
- Long frame: 50 beats of 255 with s_last on beat 50 → one frame of all 3s and one err pulse.
  - Beats 49 and 50 are dropped.
  - The next 48-beat frame is packed from idx 0.
- Reset: assert rst_n=0 asynchronously at idx=20 with m_valid=1 → m_valid=0 immediately.
  - After release, the first 48-beat frame packs correctly.
  - With HGCAL_QIN_STATS_EN defined, both counters read 0 after reset.

Source files
------------

// File: rtl/hgcal_input_quantizer.sv
// Quantizes a serial unsigned sample stream to 2-bit codes and packs
// N_CELLS codes into one frame word for the layer-0 LUT neurons.
// Ports: clk, rst_n (async low); s_valid/s_ready/s_data/s_last sample in;
// m_valid/m_ready/m_data frame out; err_frame one-cycle malformed pulse.
// Optional HGCAL_QIN_STATS_EN: frames_out/frames_err saturating counters.
module hgcal_input_quantizer #(
  parameter int N_CELLS = 48,
  parameter int IN_W    = 8,
  parameter int Q_W     = 2,
  parameter int T1      = 8,
  parameter int T2      = 32,
  parameter int T3      = 96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N_CELLS*Q_W-1:0] m_data,
  output logic                   err_frame
`ifdef HGCAL_QIN_STATS_EN
  ,
  output logic [15:0]            frames_out,
  output logic [15:0]            frames_err
`endif
);

  localparam int FW    = N_CELLS * Q_W;
  localparam int IDX_W = $clog2(N_CELLS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CELLS - 1);
  localparam logic [IN_W-1:0]  TH1  = IN_W'(T1);
  localparam logic [IN_W-1:0]  TH2  = IN_W'(T2);
  localparam logic [IN_W-1:0]  TH3  = IN_W'(T3);

  if (Q_W != 2 || T1 > T2 || T2 > T3 || T3 >= (1 << IN_W))
  begin : g_bad_params
    $error("hgcal_input_quantizer: bad Q_W or thresholds");
  end

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [FW-1:0]    fill, fill_nxt;
  logic [FW-1:0]    fill_beat, data_nxt;
  logic             long_q, long_nxt;
  logic             valid_nxt, err_nxt;
  logic [Q_W-1:0]   code;
  logic             beat, oreg_free, at_end;

  always_comb begin
    if (s_data >= TH3)      code = 2'd3;
    else if (s_data >= TH2) code = 2'd2;
    else if (s_data >= TH1) code = 2'd1;
    else                    code = 2'd0;
  end

  assign s_ready   = (state != WAIT);
  assign beat      = s_valid && s_ready;
  assign oreg_free = !m_valid || m_ready;
  assign at_end    = (idx == LAST);

  always_comb begin
    fill_beat = fill;
    fill_beat[idx*Q_W +: Q_W] = code;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    fill_nxt  = fill;
    long_nxt  = long_q;
    data_nxt  = m_data;
    valid_nxt = m_valid && !m_ready;
    err_nxt   = 1'b0;
    unique case (state)
      FILL: begin
        if (beat) begin
          fill_nxt = fill_beat;
          idx_nxt  = idx + 1'b1;
          if (at_end || s_last) begin
            // Short or long frames are both flagged; only long drops.
            err_nxt  = at_end ^ s_last;
            long_nxt = at_end && !s_last;
            if (oreg_free) begin
              data_nxt  = fill_beat;
              valid_nxt = 1'b1;
              fill_nxt  = '0;
              idx_nxt   = '0;
              state_nxt = long_nxt ? DROP : FILL;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (oreg_free) begin
          data_nxt  = fill;
          valid_nxt = 1'b1;
          fill_nxt  = '0;
          idx_nxt   = '0;
          state_nxt = long_q ? DROP : FILL;
        end
      end
      DROP: begin
        if (beat && s_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      fill      <= '0;
      long_q    <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      fill      <= fill_nxt;
      long_q    <= long_nxt;
      m_data    <= data_nxt;
      m_valid   <= valid_nxt;
      err_frame <= err_nxt;
    end
  end

`ifdef HGCAL_QIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_out <= '0;
      frames_err <= '0;
    end else begin
      if (m_valid && m_ready && frames_out != 16'hFFFF)
        frames_out <= frames_out + 16'd1;
      if (err_frame && frames_err != 16'hFFFF)
        frames_err <= frames_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Randomized and directed bench for hgcal_input_quantizer.
// Frames are predicted from the sample lists by a threshold-count model.
module tb_hgcal_input_quantizer;

  localparam int N  = 48;
  localparam int FW = 96;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last;
  logic [7:0]    s_data;
  logic          m_valid, m_ready;
  logic [FW-1:0] m_data;
  logic          err_frame;
`ifdef HGCAL_QIN_STATS_EN
  logic [15:0]   frames_out, frames_err;
`endif

  hgcal_input_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_frame (err_frame)
`ifdef HGCAL_QIN_STATS_EN
    ,
    .frames_out(frames_out),
    .frames_err(frames_err)
`endif
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            err_seen = 0;
  int            err_exp = 0;
  int            n_frames = 0;
  bit            rnd_rdy = 0;
  bit            rnd_gap = 0;
  logic [7:0]    smp[$];
  logic [FW-1:0] expq[$];
  logic [FW-1:0] exp_w;

  function automatic logic [FW-1:0] model();
    logic [FW-1:0] w = '0;
    for (int i = 0; i < smp.size() && i < N; i++)
      w[2*i +: 2] = 2'(int'(smp[i] >= 8) + int'(smp[i] >= 32)
                     + int'(smp[i] >= 96));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs,
                     input logic [FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit ok = 0;
    int n = 0;
    if (rnd_gap) repeat ($urandom_range(0, 2)) tick();
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      ok = s_ready;
      tick();
      n++;
    end while (!ok && n < 500);
    if (!ok) chk("beat_timeout", 0, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame();
    expq.push_back(model());
    if (smp.size() != N) err_exp++;
    foreach (smp[i]) send(smp[i], i == smp.size() - 1);
  endtask

  task automatic drain();
    int n = 0;
    rnd_rdy = 0;
    m_ready = 1'b1;
    while (expq.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("drain_pending", FW'(expq.size()), 0);
    chk("err_count", FW'(err_seen), FW'(err_exp));
  endtask

  task automatic fill_smp(input int n, input int kind);
    smp.delete();
    for (int i = 0; i < n; i++)
      case (kind)
        0: smp.push_back(8'hFF);
        1: smp.push_back(8'h00);
        2: begin
          logic [31:0] v = (i % 4 == 0) ? 0 : (i % 4 == 1) ? 8
                         : (i % 4 == 2) ? 32 : 96;
          smp.push_back(v[7:0]);
        end
        default: smp.push_back(8'($urandom_range(0, 255)));
      endcase
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_frame) err_seen++;
      if (m_valid && m_ready) begin
        n_frames++;
        n_vec++;
        if (expq.size() == 0) begin
          n_err++;
          $error("FAIL frame_extra observed=%h expected=none", m_data);
        end else begin
          exp_w = expq.pop_front();
          assert (m_data === exp_w) else begin
            n_err++;
            $error("FAIL frame observed=%h expected=%h", m_data, exp_w);
          end
        end
      end
    end
  end

  initial begin
    logic [FW-1:0] ones = '1;
    logic [FW-1:0] nom  = {12{8'hE4}};
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_m_valid", FW'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", FW'(err_frame), 0);
    chk("rst_s_ready", FW'(s_ready), 1);
`ifdef HGCAL_QIN_STATS_EN
    chk("rst_frames_out", FW'(frames_out), 0);
    chk("rst_frames_err", FW'(frames_err), 0);
`endif

    // nominal frame, latency and packing
    m_ready = 1'b0;
    fill_smp(N, 2);
    send_frame();
    chk("nom_latency", FW'(m_valid), 1);
    chk("nom_data", m_data, nom);
    drain();

    // thresholds on cells 0..6
    fill_smp(N, 3);
    smp[0] = 7;  smp[1] = 8;  smp[2] = 31; smp[3] = 32;
    smp[4] = 95; smp[5] = 96; smp[6] = 255;
    m_ready = 1'b0;
    send_frame();
    chk("thr_codes", FW'(m_data[13:0]), FW'(14'b11_11_10_10_01_01_00));
    drain();

    // backpressure with a second frame waiting
    m_ready = 1'b0;
    fill_smp(N, 0);
    send_frame();
    fill_smp(N, 1);
    send_frame();
    chk("bp_s_ready", FW'(s_ready), 0);
    chk("bp_hold", m_data, ones);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("b2b_valid", FW'(m_valid), 1);
    chk("b2b_data", m_data, 0);
    chk("b2b_s_ready", FW'(s_ready), 1);
    drain();

    // short frame
    fill_smp(10, 0);
    send_frame();
    drain();

    // long frame followed by a nominal one
    fill_smp(50, 0);
    send_frame();
    fill_smp(N, 2);
    send_frame();
    drain();

    // async reset mid-frame with a held output
    m_ready = 1'b0;
    fill_smp(N, 3);
    send_frame();
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", FW'(m_valid), 0);
    chk("arst_m_data", m_data, 0);
    expq.delete();
    err_seen = 0;
    err_exp  = 0;
    n_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`ifdef HGCAL_QIN_STATS_EN
    chk("arst_frames_out", FW'(frames_out), 0);
    chk("arst_frames_err", FW'(frames_err), 0);
`endif
    m_ready = 1'b1;
    fill_smp(N, 3);
    send_frame();
    drain();

    // randomized frames, gaps and backpressure
    rnd_gap = 1;
    for (int f = 0; f < 30; f++) begin
      int r = $urandom_range(0, 9);
      int n = (r < 6) ? N : (r < 8) ? $urandom_range(1, N - 1)
            : $urandom_range(N + 1, N + 5);
      rnd_rdy = 1;
      fill_smp(n, 3);
      send_frame();
    end
    rnd_gap = 0;
    drain();
`ifdef HGCAL_QIN_STATS_EN
    chk("stat_frames_out", FW'(frames_out), FW'(n_frames));
    chk("stat_frames_err", FW'(frames_err), FW'(err_seen));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
